ifft_stage_ctrl: RTL and testbench

Sequencer for the radix-2 IFFT butterfly stage in a 32-point in-place/ping-pong IFFT. Runs 5 DIF passes of 16 butterflies each. For each butterfly it issues two operand read addresses to the ping-pong sample buffer and the twiddle select for the butterfly stage. It then delays the addresses by the buffer-plus-datapath latency, generates aligned write-backs, and drains the pipeline between passes.

---
 rtl/ifft_stage_ctrl.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_ifft_stage_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// ifft_stage_ctrl
//
// Sequencer for the radix-2 butterfly stage of a 32-point ping-pong IFFT.
// It runs 5 DIF passes of 16 butterflies each. For every butterfly it issues
// two operand read addresses and a twiddle select. The addresses then travel
// through a D = MEM_LAT + DP_LAT deep pipeline so that the write-back strobe
// lines up with the butterfly results. The pipeline drains between passes.
//
// Optional feature (compile-time macro IFFT_CTRL_BITREV_EN):
//   defined   : stage-4 write addresses are bit-reversed, so the result bank
//               ends up in natural order.
//   undefined : every write uses natural addresses, so the result bank ends
//               up in bit-reversed order.
//
// Parameters:
//   DP_LAT    butterfly datapath latency (operands in -> results valid)
//   MEM_LAT   sample-buffer read latency
//   TW_SHIFT  left shift from the 4-bit twiddle index to the 7-bit ROM select
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   begin a transform (only looked at in IDLE)
//   busy       out  transform in progress, through the last write-back
//   done       out  one-cycle pulse after the final write-back
//   stage      out  current pass 0..4
//   rd_bank    out  bank being read; the write bank is ~rd_bank
//   rd_en      out  operand read strobe
//   rd_addr_a  out  operand A address
//   rd_addr_b  out  operand B address
//   twsel      out  twiddle ROM select, aligned with the read data
//   wr_en      out  result write strobe
//   wr_addr_a  out  result 1 address
//   wr_addr_b  out  result 2 address
//   dbg_state  out  current FSM state (IDLE=0, ISSUE=1, DRAIN=2, FIN=3)
//
// Handshake: there is no backpressure. A start is accepted only in IDLE on
// the edge where it is sampled high; a start seen in any other state is
// dropped. rd_en and wr_en are single-cycle strobes that the buffer must
// accept unconditionally on the cycle they are high.
// ---------------------------------------------------------------------------
module ifft_stage_ctrl #(
   parameter int DP_LAT   = 5,
   parameter int MEM_LAT  = 1,
   parameter int TW_SHIFT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [2:0] stage,
   output logic       rd_bank,
   output logic       rd_en,
   output logic [4:0] rd_addr_a,
   output logic [4:0] rd_addr_b,
   output logic [6:0] twsel,
   output logic       wr_en,
   output logic [4:0] wr_addr_a,
   output logic [4:0] wr_addr_b,
   output logic [1:0] dbg_state
);

   localparam int         D          = MEM_LAT + DP_LAT;
   localparam logic [7:0] DRAIN_LAST = 8'(D - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------
   state_t     r_state, w_state_nxt;
   logic [3:0] r_k,     w_k_nxt;
   logic [2:0] r_stage, w_stage_nxt;
   logic       r_bank,  w_bank_nxt;
   logic [7:0] r_cnt,   w_cnt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_k     <= 4'd0;
         r_stage <= 3'd0;
         r_bank  <= 1'b0;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_stage <= w_stage_nxt;
         r_bank  <= w_bank_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_stage_nxt = r_stage;
      w_bank_nxt  = r_bank;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_ISSUE;
               w_k_nxt     = 4'd0;
               w_stage_nxt = 3'd0;
               w_bank_nxt  = 1'b0;
            end
         end
         S_ISSUE: begin
            if (r_k == 4'd15) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_k_nxt = r_k + 4'd1;
            end
         end
         S_DRAIN: begin
            if (r_cnt == DRAIN_LAST) begin
               // Toggling on the last pass too leaves rd_bank pointing at
               // the bank that holds the finished result.
               w_bank_nxt = ~r_bank;
               if (r_stage == 3'd4) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_ISSUE;
                  w_stage_nxt = r_stage + 3'd1;
                  w_k_nxt     = 4'd0;
               end
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Butterfly address / twiddle generation
   // rd_addr_a is k with a zero inserted at bit (4 - stage): the bits of k
   // at and above that position move up by one, the bits below stay put.
   // ------------------------------------------------------------------
   logic [2:0] w_pos;
   logic [4:0] w_low_mask;
   logic [4:0] w_k5;
   logic [4:0] w_addr_a;
   logic [4:0] w_addr_b;
   logic [3:0] w_tw_idx;
   logic [6:0] w_twsel;

   always_comb begin
      w_pos      = 3'd4 - r_stage;
      w_low_mask = (5'd1 << w_pos) - 5'd1;
      w_k5       = {1'b0, r_k};
      w_addr_a   = ((w_k5 & ~w_low_mask) << 1) | (w_k5 & w_low_mask);
      w_addr_b   = w_addr_a | (5'd1 << w_pos);
      w_tw_idx   = (r_k & w_low_mask[3:0]) << r_stage;
      w_twsel    = 7'({3'b000, w_tw_idx} << TW_SHIFT);
   end

   // ------------------------------------------------------------------
   // Registered issue outputs (one cycle behind the sequencer state)
   // ------------------------------------------------------------------
   logic       r_rd_en;
   logic       r_busy;
   logic       r_done;
   logic [2:0] r_stage_o;
   logic       r_bank_o;
   logic [4:0] r_rd_a;
   logic [4:0] r_rd_b;
   logic [6:0] r_tw_iss;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_stage_o <= 3'd0;
         r_bank_o  <= 1'b0;
         r_rd_a    <= 5'd0;
         r_rd_b    <= 5'd0;
         r_tw_iss  <= 7'd0;
      end else begin
         r_rd_en   <= (r_state == S_ISSUE);
         r_busy    <= (r_state == S_ISSUE) || (r_state == S_DRAIN);
         r_done    <= (r_state == S_FIN);
         r_stage_o <= r_stage;
         r_bank_o  <= r_bank;
         if (r_state == S_ISSUE) begin
            r_rd_a   <= w_addr_a;
            r_rd_b   <= w_addr_b;
            r_tw_iss <= w_twsel;
         end else begin
            r_rd_a   <= 5'd0;
            r_rd_b   <= 5'd0;
            r_tw_iss <= 7'd0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Write address selection (natural or stage-4 bit-reversed)
   // ------------------------------------------------------------------
   logic [4:0] w_ld_a;
   logic [4:0] w_ld_b;

`ifdef IFFT_CTRL_BITREV_EN
   always_comb begin
      if (r_stage_o == 3'd4) begin
         w_ld_a = {r_rd_a[0], r_rd_a[1], r_rd_a[2], r_rd_a[3], r_rd_a[4]};
         w_ld_b = {r_rd_b[0], r_rd_b[1], r_rd_b[2], r_rd_b[3], r_rd_b[4]};
      end else begin
         w_ld_a = r_rd_a;
         w_ld_b = r_rd_b;
      end
   end
`else
   assign w_ld_a = r_rd_a;
   assign w_ld_b = r_rd_b;
`endif

   // ------------------------------------------------------------------
   // Write-back pipeline: D stages, loaded from the registered issue
   // outputs, so wr_en trails rd_en by exactly D cycles.
   // ------------------------------------------------------------------
   logic       r_pv [D];
   logic [4:0] r_pa [D];
   logic [4:0] r_pb [D];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < D; i++) begin
            r_pv[i] <= 1'b0;
            r_pa[i] <= 5'd0;
            r_pb[i] <= 5'd0;
         end
      end else begin
         r_pv[0] <= r_rd_en;
         r_pa[0] <= w_ld_a;
         r_pb[0] <= w_ld_b;
         for (int i = 1; i < D; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pa[i] <= r_pa[i-1];
            r_pb[i] <= r_pb[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Twiddle delay: the ROM select must meet the operand data, which
   // arrives MEM_LAT cycles after the read strobe.
   // ------------------------------------------------------------------
   generate
      if (MEM_LAT == 0) begin : g_tw_nodly
         assign twsel = r_tw_iss;
      end else begin : g_tw_dly
         logic [6:0] r_tw_d [MEM_LAT];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < MEM_LAT; i++) begin
                  r_tw_d[i] <= 7'd0;
               end
            end else begin
               r_tw_d[0] <= r_tw_iss;
               for (int i = 1; i < MEM_LAT; i++) begin
                  r_tw_d[i] <= r_tw_d[i-1];
               end
            end
         end
         assign twsel = r_tw_d[MEM_LAT-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   assign busy      = r_busy;
   assign done      = r_done;
   assign stage     = r_stage_o;
   assign rd_bank   = r_bank_o;
   assign rd_en     = r_rd_en;
   assign rd_addr_a = r_rd_a;
   assign rd_addr_b = r_rd_b;
   assign wr_en     = r_pv[D-1];
   assign wr_addr_a = r_pa[D-1];
   assign wr_addr_b = r_pb[D-1];
   assign dbg_state = r_state;

endmodule

// File: tb/tb_ifft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifft_stage_ctrl
//
// Bench for ifft_stage_ctrl. A reference model builds, per transform, the
// cycle-by-cycle expected strobes plus an ordered queue of expected
// write-backs, computed from the butterfly grouping rules (group/offset
// arithmetic). Runs include random idle gaps, stray start pulses during a
// transform and a random mid-transform reset.
// ---------------------------------------------------------------------------
module tb_ifft_stage_ctrl;

   localparam int DP_LAT   = 5;
   localparam int MEM_LAT  = 1;
   localparam int TW_SHIFT = 2;
   localparam int D        = DP_LAT + MEM_LAT;
   localparam int PASS_LEN = 16 + D;
   localparam int LAST_WR  = 5 * PASS_LEN;
   localparam int DONE_CYC = LAST_WR + 1;
   localparam int NCYC     = DONE_CYC + 12;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;

   always #5 clk = ~clk;

   logic       busy, done, rd_bank, rd_en, wr_en;
   logic [2:0] stage;
   logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [6:0] twsel;
   logic [1:0] dbg_state;

   ifft_stage_ctrl #(
      .DP_LAT  (DP_LAT),
      .MEM_LAT (MEM_LAT),
      .TW_SHIFT(TW_SHIFT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .stage    (stage),
      .rd_bank  (rd_bank),
      .rd_en    (rd_en),
      .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b),
      .twsel    (twsel),
      .wr_en    (wr_en),
      .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;

   logic [9:0] exp_q[$];           // expected {wr_addr_a, wr_addr_b} in order

   int e_rd_en [NCYC];
   int e_wr_en [NCYC];
   int e_busy  [NCYC];
   int e_done  [NCYC];
   int e_a     [NCYC];
   int e_b     [NCYC];
   int e_stage [NCYC];
   int e_bank  [NCYC];
   int e_tw_v  [NCYC];
   int e_tw    [NCYC];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int bit_rev5(input int x);
      int r;
      r = 0;
      for (int i = 0; i < 5; i++) r = r * 2 + ((x >> i) & 1);
      return r;
   endfunction

   // ---------------- reference model ----------------
   task automatic build_model();
      int t, half, grp, off, a, b, j, wa, wb;
      for (int n = 0; n < NCYC; n++) begin
         e_rd_en[n] = 0; e_wr_en[n] = 0; e_a[n] = 0; e_b[n] = 0;
         e_stage[n] = 0; e_bank[n] = 0; e_tw_v[n] = 0; e_tw[n] = 0;
         e_busy[n]  = (n >= 1 && n <= LAST_WR) ? 1 : 0;
         e_done[n]  = (n == DONE_CYC) ? 1 : 0;
      end
      exp_q.delete();
      for (int s = 0; s < 5; s++) begin
         half = 16 >> s;
         for (int k = 0; k < 16; k++) begin
            grp = k / half;
            off = k % half;
            a   = grp * 2 * half + off;
            b   = a + half;
            j   = off * (1 << s);
            t   = 1 + s * PASS_LEN + k;
            e_rd_en[t] = 1;
            e_a[t] = a;
            e_b[t] = b;
            e_stage[t] = s;
            e_bank[t] = s % 2;
            e_tw_v[t + MEM_LAT] = 1;
            e_tw[t + MEM_LAT] = j * (1 << TW_SHIFT);
            e_wr_en[t + D] = 1;
            wa = a;
            wb = b;
`ifdef IFFT_CTRL_BITREV_EN
            if (s == 4) begin
               wa = bit_rev5(a);
               wb = bit_rev5(b);
            end
`endif
            exp_q.push_back({5'(wa), 5'(wb)});
         end
      end
   endtask

   // ---------------- per-cycle checks ----------------
   task automatic check_cycle(input int n);
      logic [9:0] x;
      check_eq($sformatf("rd_en@%0d", n), rd_en, e_rd_en[n]);
      check_eq($sformatf("wr_en@%0d", n), wr_en, e_wr_en[n]);
      check_eq($sformatf("busy@%0d", n), busy, e_busy[n]);
      check_eq($sformatf("done@%0d", n), done, e_done[n]);
      if (e_rd_en[n] != 0) begin
         check_eq($sformatf("rd_addr_a@%0d", n), rd_addr_a, e_a[n]);
         check_eq($sformatf("rd_addr_b@%0d", n), rd_addr_b, e_b[n]);
         check_eq($sformatf("stage@%0d", n), stage, e_stage[n]);
         check_eq($sformatf("rd_bank@%0d", n), rd_bank, e_bank[n]);
      end
      if (e_tw_v[n] != 0) check_eq($sformatf("twsel@%0d", n), twsel, e_tw[n]);
      if (n >= DONE_CYC) check_eq($sformatf("rd_bank_final@%0d", n), rd_bank, 1);
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq($sformatf("wr_extra@%0d", n), wr_en, 0);
         end else begin
            x = exp_q.pop_front();
            check_eq($sformatf("wr_addr@%0d", n), {wr_addr_a, wr_addr_b}, x);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ctl"}, {busy, done, stage, rd_bank, rd_en, wr_en}, 0);
      check_eq({tag, "_addr"}, {rd_addr_a, rd_addr_b, twsel, wr_addr_a, wr_addr_b}, 0);
   endtask

   // ---------------- driver ----------------
   // n_ign > 0 adds stray start pulses (always cycles 5 and 50, plus random).
   // rst_at >= 0 pulls reset low partway through cycle rst_at.
   task automatic run_transform(input int n_ign, input int rst_at);
      int ign[$];
      int c_rd, c_wr, c_done;
      logic hit;
      c_rd = 0; c_wr = 0; c_done = 0;
      if (n_ign > 0) begin
         ign.push_back(5);
         ign.push_back(50);
         for (int i = 2; i < n_ign; i++) ign.push_back($urandom_range(2, 100));
      end
      build_model();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start = 1'b1;
      @(posedge clk);                       // edge 0: start accepted
      #1;
      start = 1'b0;
      for (int n = 0; n < NCYC; n++) begin
         check_cycle(n);
         if (rd_en === 1'b1) c_rd++;
         if (wr_en === 1'b1) c_wr++;
         if (done === 1'b1) c_done++;
         if (n == rst_at) begin
            #2;
            rst = 1'b0;
            #1;
            check_all_zero($sformatf("rst_now@%0d", n));
            repeat (2) @(negedge clk);
            rst = 1'b1;
            for (int m = 0; m < 40; m++) begin
               @(posedge clk);
               #1;
               check_eq($sformatf("post_rst_wr_en@%0d", m), wr_en, 0);
               check_eq($sformatf("post_rst_rd_en@%0d", m), rd_en, 0);
               check_eq($sformatf("post_rst_busy@%0d", m), busy, 0);
            end
            exp_q.delete();
            return;
         end
         hit = 1'b0;
         foreach (ign[i]) if (ign[i] == n) hit = 1'b1;
         start = hit;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check_eq("rd_count", c_rd, 80);
      check_eq("wr_count", c_wr, 80);
      check_eq("done_count", c_done, 1);
      check_eq("wr_left", exp_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      run_transform(0, -1);
      run_transform(2, -1);
      run_transform(0, 30);
      run_transform(0, -1);
      run_transform(0, $urandom_range(2, 105));
      run_transform($urandom_range(3, 6), -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no completion, expected finish before 500000");
      $fatal(1, "timeout");
   end

endmodule
